// File: rtl/issue_stage_if.sv
// Fetch, execute and writeback signal bundle for issue_stage.
// The slave modport is the issue stage; the master modport is the surrounding pipeline.
interface issue_stage_if #(
    parameter int unsigned DW = 32
);
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic          if_ready;
    logic          flush;
    logic          ex_stall;
    logic          wb_en;
    logic [4:0]    wb_reg;
    logic [DW-1:0] wb_data;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [5:0]    ex_op;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_rd;
    logic [10:0]   ex_aux;
    logic [DW-1:0] ex_os;
    logic [DW-1:0] ex_ot;
    logic [DW-1:0] ex_imm_dpl;

    modport slave (
        input  if_valid, if_pc, if_instr, flush, ex_stall, wb_en, wb_reg, wb_data,
        output if_ready, ex_valid, ex_pc, ex_op, ex_rs, ex_rt, ex_rd, ex_aux,
               ex_os, ex_ot, ex_imm_dpl
    );

    modport master (
        output if_valid, if_pc, if_instr, flush, ex_stall, wb_en, wb_reg, wb_data,
        input  if_ready, ex_valid, ex_pc, ex_op, ex_rs, ex_rt, ex_rd, ex_aux,
               ex_os, ex_ot, ex_imm_dpl
    );
endinterface

// File: rtl/issue_stage.sv
// Decode/issue stage: field split, 32-entry register file, pending-write scoreboard, registered ex_* outputs.
// Optional ISSUE_FWD_EN: same-cycle writeback bypass into hazard check and operands.
module issue_stage #(
    parameter int unsigned   DW       = 32,
    parameter logic [DW-1:0] RF_RESET = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_stage_if.slave bus
);
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned IW   = 16;

    logic [5:0]      op;
    logic [RW-1:0]   rs, rt, rd, dest, ex_dest;
    logic [10:0]     aux;
    logic [IW-1:0]   imm;
    logic            use_rs, use_rt, zext, has_dest;
    logic            pend_rs, pend_rt, hazard, accept, wb_act;
    logic [DW-1:0]   imm_ext, os_val, ot_val;
    logic [NREG-1:0] pending, pending_nxt;
    logic [DW-1:0]   rf [NREG];

    assign op  = bus.if_instr[31:26];
    assign rs  = bus.if_instr[25:21];
    assign rt  = bus.if_instr[20:16];
    assign rd  = bus.if_instr[15:11];
    assign aux = bus.if_instr[10:0];
    assign imm = bus.if_instr[15:0];

    // Per-op destination, source usage and immediate extension
    always_comb begin : decode
        dest   = '0;
        use_rs = 1'b1;
        use_rt = 1'b0;
        zext   = 1'b0;
        case (op)
            6'd0:                begin dest = rd; use_rt = 1'b1; end
            6'd1, 6'd16, 6'd18,
            6'd20:               dest = rt;
            6'd3:                begin dest = rt; use_rs = 1'b0; end
            6'd4, 6'd5, 6'd6:    begin dest = rt; zext = 1'b1; end
            6'd24, 6'd26, 6'd28: use_rt = 1'b1;
            6'd41:               begin dest = RW'(31); use_rs = 1'b0; end
            default:             dest = '0;
        endcase
    end

    assign has_dest = (dest != '0);
    assign imm_ext  = zext ? {{(DW-IW){1'b0}}, imm} : {{(DW-IW){imm[IW-1]}}, imm};
    assign wb_act   = bus.wb_en && (bus.wb_reg != '0);

`ifdef ISSUE_FWD_EN
    logic wb_rs_hit, wb_rt_hit;
    assign wb_rs_hit = wb_act && (bus.wb_reg == rs);
    assign wb_rt_hit = wb_act && (bus.wb_reg == rt);
    assign pend_rs   = pending[rs] && !wb_rs_hit;
    assign pend_rt   = pending[rt] && !wb_rt_hit;
    assign os_val    = wb_rs_hit ? bus.wb_data : rf[rs];
    assign ot_val    = wb_rt_hit ? bus.wb_data : rf[rt];
`else
    assign pend_rs   = pending[rs];
    assign pend_rt   = pending[rt];
    assign os_val    = rf[rs];
    assign ot_val    = rf[rt];
`endif

    // Destination check stays registered: same-cycle wb does not relax WAW
    assign hazard       = (use_rs && pend_rs) || (use_rt && pend_rt) || (has_dest && pending[dest]);
    assign bus.if_ready = !hazard && !bus.ex_stall && !bus.flush;
    assign accept       = bus.if_valid && bus.if_ready;

    // Clears first so a same-cycle set wins; r0 is never pending
    always_comb begin : sb_next
        pending_nxt = pending;
        if (wb_act)
            pending_nxt[bus.wb_reg] = 1'b0;
        if (bus.flush && bus.ex_valid && (ex_dest != '0))
            pending_nxt[ex_dest] = 1'b0;
        if (accept && has_dest)
            pending_nxt[dest] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin : sb_reg
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    // r0 is reset to zero and never written, so reads of r0 need no special case
    always_ff @(posedge clk or negedge rst_n) begin : rf_write
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++)
                rf[i] <= (i == 0) ? '0 : RF_RESET;
        end else if (wb_act) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ex_reg
        if (!rst_n) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_op      <= '0;
            bus.ex_rs      <= '0;
            bus.ex_rt      <= '0;
            bus.ex_rd      <= '0;
            bus.ex_aux     <= '0;
            bus.ex_os      <= '0;
            bus.ex_ot      <= '0;
            bus.ex_imm_dpl <= '0;
            ex_dest        <= '0;
        end else if (accept) begin
            bus.ex_valid   <= 1'b1;
            bus.ex_pc      <= bus.if_pc;
            bus.ex_op      <= op;
            bus.ex_rs      <= rs;
            bus.ex_rt      <= rt;
            bus.ex_rd      <= rd;
            bus.ex_aux     <= aux;
            bus.ex_os      <= os_val;
            bus.ex_ot      <= ot_val;
            bus.ex_imm_dpl <= imm_ext;
            ex_dest        <= dest;
        end else if (bus.flush || !bus.ex_stall) begin
            bus.ex_valid   <= 1'b0;
        end
    end
endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the execute ALU.
- Accepts fetched instructions and splits them into op/rs/rt/rd/aux/immediate fields, and reads operands from an internal 32x32 register file.
- Tracks outstanding register writes with a scoreboard and stalls fetch on hazards.
- Presents one registered, valid-qualified instruction per cycle to execute; writeback results from the execute stage return through the wb_* ports.

Parameters:
- DW, 32, datapath and register width.
- RF_RESET, 0, value loaded into every register r1..r31 at reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch presents an instruction.
- if_pc  input  32  word address of the instruction.
- if_instr  input  32  instruction word.
- if_ready  output  1  stage accepts if_instr this cycle.
- flush  input  1  kill the instruction held in the ex_* outputs and any instruction being accepted.
- ex_stall  input  1  execute cannot consume; hold all ex_* outputs.
- wb_en  input  1  write wb_data to wb_reg.
- wb_reg  input  5  writeback destination.
- wb_data  input  32  writeback value.
- ex_valid  output  1  ex_* fields hold a live instruction.
- ex_pc  output  32  pc of that instruction.
- ex_op  output  6  instr[31:26].
- ex_rs  output  5  instr[25:21].
- ex_rt  output  5  instr[20:16].
- ex_rd  output  5  instr[15:11].
- ex_aux  output  11  instr[10:0].
- ex_os  output  32  value of register rs.
- ex_ot  output  32  value of register rt.
- ex_imm_dpl  output  32  extended instr[15:0].

Behaviour:
- Reset (async, rst_n low): ex_valid=0, all ex_* fields=0, scoreboard all clear, r0=0, r1..r31=RF_RESET. if_ready is combinational and reads 1 once out of reset with no hazard.
- Extension: ops 4, 5, 6 zero-extend; all other ops sign-extend.
- Destination: op0 -> rd; ops 1, 3, 4, 5, 6, 16, 18, 20 -> rt; op41 -> 31; otherwise none. A destination of 0 counts as none.
- Sources:
  - rs is read by all ops except 3 and 41.
  - rt is read by ops 0, 24, 26, 28.
- Scoreboard: one pending bit per register, r0 never set.
- hazard = any used source pending, OR the destination pending (WAW).
- if_ready = !hazard && !ex_stall && !flush.
- Accept = if_valid && if_ready.
- On accept, the next edge does three things:
  - loads the ex_* fields;
  - sets ex_valid=1;
  - sets the pending bit of the destination.
- If not accepted and !ex_stall: ex_valid<=0 (bubble). Fields may hold stale values.
- ex_stall=1: ex_* outputs and ex_valid hold; no accept.
- Writeback: wb_en with wb_reg!=0 writes the register and clears its pending bit on the edge. Writes to r0 are ignored.
- Same-cycle set and clear of the same bit: set wins.
- flush=1:
  - next edge ex_valid<=0, with no accept that cycle;
  - the pending bit of the flushed valid instruction's destination is cleared, unless a simultaneous wb to a different register makes that irrelevant. Both clears apply.
  - flush overrides ex_stall.
- Register read latency: operands are sampled combinationally at accept and registered into ex_os/ex_ot. Issue latency is 1 cycle.
- Reset mid-stall or mid-flush: everything returns to reset values immediately.

Optional Feature:
- ISSUE_FWD_EN defined:
  - a same-cycle wb_en to a source register counts as not pending for the hazard check;
  - wb_data is bypassed into ex_os/ex_ot, so a dependent instruction issues in the writeback cycle.
- Not defined:
  - the pending bit is checked as registered, so a dependent instruction issues one cycle after writeback;
  - the register file read reflects the write that occurred on the previous edge.

Test Plan:
- Reset, then issue op1 rs=2 rt=3 imm=16'hFFFE with r2=5 -> next cycle ex_valid=1, ex_os=5, ex_imm_dpl=32'hFFFFFFFE, pending[3]=1.
- Issue op5 imm=16'h8000 -> ex_imm_dpl=32'h00008000.
- RAW hazard: issue op0 rd=4, then op0 rs=4 -> if_ready=0 until wb_en wb_reg=4 wb_data=9.
  - With ISSUE_FWD_EN: dependent instruction issues in the wb cycle with ex_os=9.
  - Without ISSUE_FWD_EN: issues one cycle later, also with ex_os=9.
- ex_stall=1 for 3 cycles with ex_valid=1 -> all ex_* outputs held, if_ready=0; release -> next instruction issues.
- flush while ex holds op41 (dest 31) -> ex_valid=0 next cycle, pending[31]=0, an instruction reading r31 issues immediately.
- wb_en to r0 with wb_data=32'hDEAD, then read r0 -> ex_os=0; assert rst_n low mid-hazard -> ex_valid=0 and scoreboard clear asynchronously.
